conversion_sched: RTL and testbench
===================================

# conversion_sched

Time-shared unit-conversion engine that replaces per-channel combinational dividers with one iterative divider shared between NREQ requesters. Each requester presents a 19-bit raw measurement and a 2-bit conversion mode. A round-robin arbiter grants one request at a time, and a 23-step restoring divider computes the converted value. The block sits between the measurement front-ends and the display/formatting logic and returns each result with a one-cycle done pulse tagged with the requester id.

## Interface

- NREQ, 2: number of requesters; legal values are 2..4.
- IDW, 2: width of done_id; must satisfy 2^IDW >= NREQ.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  NREQ  per-requester request level.
- req_data  in  19*NREQ  operand; slice i is bits [19i+18:19i].
- req_mode  in  2*NREQ  conversion mode; slice i is bits [2i+1:2i].
- grant  out  NREQ  one-hot, combinational; high in the acceptance cycle.
- busy  out  1  conversion in flight (state DIV).
- done  out  1  registered one-cycle pulse; result is valid.
- done_id  out  IDW  index of the requester that owns the result.
- result  out  19  converted value; holds until the next done.

## Operation

- Modes, all using floor (truncating) division:
  - 00: data / 100.
  - 01: data, passed through with no division.
  - 10: data / 30.
  - 11: (data * 12) / 30.
- Operand width rules:
  - Dividend is 23 bits: data zero-extended, or data*12 for mode 11.
  - Divisor is 7 bits (100 or 30).
  - Quotient keeps its low 19 bits. The maximum mode-11 result is 209714, so nothing is lost.
- States:
  - IDLE: grant asserted for the round-robin winner whenever any req bit is high. At that edge the block latches the winner's data, mode and id, and advances the pointer to winner+1 mod NREQ.
    - Mode 01: result<=data, done<=1, done_id<=id; stay in IDLE.
    - Other modes: load the dividend and clear the remainder; go to DIV with counter=22.
  - DIV: one restoring step per edge, MSB first: shift the remainder in, compare, subtract, set the quotient bit.
    - On the edge where counter==0: result<=quotient, done<=1, done_id<=latched id; go to IDLE.
    - Otherwise decrement the counter.
- Arbitration:
  - The pointer resets to 0. The winner is the first asserted req scanning pointer, pointer+1, … with wrap-around.
  - grant is forced to 0 outside IDLE and while rst is high.
- Requester protocol:
  - Hold req, data and mode stable until grant is seen.
  - Deassert req the cycle after grant. A req still high after the grant cycle is a new request.
  - req may be raised at any time and waits while busy.
- Simultaneous requests: exactly one grant per acceptance. The others wait, and fairness is strict rotation.
- done is high for exactly one cycle per accepted request. Results are never dropped.

## Timing

- Reset values: state=IDLE, pointer=0, busy=0, done=0, done_id=0, result=0, grant=0, counter=0.
- Reset mid-conversion aborts the operation immediately (asynchronous). No done is produced for the in-flight request; the requester must re-request.
- Divide modes:
  - Acceptance (grant high) is cycle 0; busy is high in cycles 1–23.
  - done and result are visible in cycle 24.
  - The next grant can occur in cycle 24, the same cycle as done.
- Mode 01: done is high in cycle 1; the next grant is possible in cycle 1.
- Sustained throughput: one divide conversion per 24 cycles.

## Test plan

- Single request, mode 00, data=12345: grant[0] high at cycle 0, busy high for cycles 1–23, done at cycle 24 with result=123 and done_id=0.
- Mode 11, data=524287 → result=209714. Mode 10, data=29 → 0. Mode 10, data=30 → 1. Mode 00, data=0 → 0.
- Mode 01, data=0x7FFFF: done at cycle 1 with result=0x7FFFF; busy never asserted.
- req=2'b11 held continuously with NREQ=2: grants alternate 0,1,0,1 every 24 cycles, starting with 0 after reset; each done_id matches its grant.
- Request from id 1 during an id-0 conversion: grant[1] is withheld until the cycle id-0's done is high, then granted in that same cycle.
- rst asserted at cycle 10 of a mode-00 conversion: all outputs go to their reset values immediately, and no done follows. A new request after rst falls completes normally with pointer=0.

Source files
------------

// File: rtl/conversion_sched_if.sv
// ---------------------------------------------------------------------------
// conversion_sched_if
//   Bundle of the requester-side handshake and the result-return signals of
//   the shared conversion engine.
//
//   req       requester -> engine   per-requester request level (NREQ bits)
//   req_data  requester -> engine   19-bit operand per requester, slice i at
//                                   [19i+18:19i]
//   req_mode  requester -> engine   2-bit conversion mode per requester,
//                                   slice i at [2i+1:2i]
//   grant     engine -> requester   one-hot acceptance strobe (combinational)
//   busy      engine -> requester   a divide is in flight
//   done      engine -> requester   one-cycle pulse, result is valid
//   done_id   engine -> requester   owner of the result
//   result    engine -> requester   converted value, held until next done
//
//   master: the requester/consumer side.  slave: the conversion engine.
// ---------------------------------------------------------------------------
interface conversion_sched_if #(
    parameter int NREQ = 2,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]    req;
    logic [19*NREQ-1:0] req_data;
    logic [2*NREQ-1:0]  req_mode;
    logic [NREQ-1:0]    grant;
    logic               busy;
    logic               done;
    logic [IDW-1:0]     done_id;
    logic [18:0]        result;

    modport master (
        output req, req_data, req_mode,
        input  grant, busy, done, done_id, result
    );

    modport slave (
        input  req, req_data, req_mode,
        output grant, busy, done, done_id, result
    );
endinterface

// File: rtl/conversion_sched.sv
// ---------------------------------------------------------------------------
// conversion_sched
//   Time-shared unit-conversion engine. NREQ requesters share one 23-step
//   restoring divider; a round-robin arbiter accepts one request at a time.
//   Modes (floor division):
//     00: data / 100     01: data (no division)
//     10: data / 30      11: (data * 12) / 30
//
//   clk   system clock, rising edge
//   rst   asynchronous active-high reset
//   bus   conversion_sched_if.slave: req/req_data/req_mode in,
//         grant/busy/done/done_id/result out
// ---------------------------------------------------------------------------
module conversion_sched #(
    parameter int NREQ = 2,
    parameter int IDW  = 2
) (
    input  logic              clk,
    input  logic              rst,
    conversion_sched_if.slave bus
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_DIV  = 1'b1;

    logic [0:0]     state;
    logic [IDW-1:0] ptr;
    logic [4:0]     count;
    logic [22:0]    dvd;
    logic [6:0]     rem;
    logic [6:0]     divisor;
    logic [IDW-1:0] id_q;

    logic           found;
    int             win_idx;
    int             scan_idx;
    logic [18:0]    win_data;
    logic [1:0]     win_mode;
    logic           accept;
    logic [IDW-1:0] next_ptr;
    logic [22:0]    dividend_load;

    logic [7:0]     trial;
    logic           trial_ge;
    logic [6:0]     rem_next;
    logic [22:0]    dvd_next;

    // Round-robin scan starting at the pointer, wrapping at NREQ.
    // The first asserted request wins and its operand slices are selected.
    always_comb begin
        found    = 1'b0;
        win_idx  = 0;
        scan_idx = 0;
        win_data = '0;
        win_mode = '0;
        for (int i = 0; i < NREQ; i++) begin
            scan_idx = int'(ptr) + i;
            if (scan_idx >= NREQ)
                scan_idx = scan_idx - NREQ;
            if (!found && bus.req[scan_idx]) begin
                found    = 1'b1;
                win_idx  = scan_idx;
                win_data = bus.req_data[19*scan_idx +: 19];
                win_mode = bus.req_mode[2*scan_idx +: 2];
            end
        end
    end

    // Acceptance is only possible in IDLE and never while reset is held,
    // so grant drops asynchronously with rst.
    always_comb begin
        accept        = (state == ST_IDLE) && found && !rst;
        next_ptr      = (win_idx == NREQ - 1) ? '0 : IDW'(win_idx + 1);
        dividend_load = (win_mode == 2'b11)
                        ? (({4'b0, win_data} << 3) + ({4'b0, win_data} << 2))
                        : {4'b0, win_data};
    end

    always_comb begin
        bus.grant = '0;
        for (int i = 0; i < NREQ; i++)
            bus.grant[i] = accept && (win_idx == i);
    end

    // One restoring step: shift the next dividend bit into the remainder,
    // subtract the divisor if it fits, and shift the quotient bit into the
    // freed LSB of the dividend register. After 23 steps dvd is the quotient.
    always_comb begin
        trial    = {rem, dvd[22]};
        trial_ge = (trial >= {1'b0, divisor});
        rem_next = trial_ge ? 7'(trial - {1'b0, divisor}) : trial[6:0];
        dvd_next = {dvd[21:0], trial_ge};
    end

    assign bus.busy = (state == ST_DIV);

    // Control, divider datapath and registered result outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            ptr         <= '0;
            count       <= '0;
            dvd         <= '0;
            rem         <= '0;
            divisor     <= '0;
            id_q        <= '0;
            bus.done    <= 1'b0;
            bus.done_id <= '0;
            bus.result  <= '0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        ptr  <= next_ptr;
                        id_q <= IDW'(win_idx);
                        if (win_mode == 2'b01) begin
                            bus.result  <= win_data;
                            bus.done    <= 1'b1;
                            bus.done_id <= IDW'(win_idx);
                        end else begin
                            dvd     <= dividend_load;
                            rem     <= '0;
                            divisor <= (win_mode == 2'b00) ? 7'd100 : 7'd30;
                            count   <= 5'd22;
                            state   <= ST_DIV;
                        end
                    end
                end
                ST_DIV: begin
                    dvd <= dvd_next;
                    rem <= rem_next;
                    if (count == 5'd0) begin
                        // Quotient never exceeds 19 bits for these modes.
                        bus.result  <= dvd_next[18:0];
                        bus.done    <= 1'b1;
                        bus.done_id <= id_q;
                        state       <= ST_IDLE;
                    end else begin
                        count <= count - 5'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conversion_sched.sv
// ---------------------------------------------------------------------------
// tb_conversion_sched
//   Self-checking bench for conversion_sched with NREQ=2. A transaction-level
//   model (engine free time, pending result, rotating pointer) predicts every
//   output each cycle; directed sequences pin literal values.
// ---------------------------------------------------------------------------
module tb_conversion_sched;

    localparam int NREQ = 2;
    localparam int IDW  = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    conversion_sched_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

    conversion_sched #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    int vec_count   = 0;
    int miscompares = 0;
    bit checking    = 1'b0;

    // Requester-side stimulus state.
    logic        rq [NREQ];
    logic [18:0] dt [NREQ];
    logic [1:0]  md [NREQ];

    // Model state: cycle index, when the engine is free again, the single
    // outstanding result and the round-robin pointer.
    int              cyc        = 0;
    int              free_cycle = 0;
    bit              last_div   = 1'b0;
    bit              pend_valid = 1'b0;
    int              pend_cycle = 0;
    int              pend_id    = 0;
    int              pend_val   = 0;
    int              ptr_m      = 0;
    logic [NREQ-1:0] exp_grant  = '0;
    logic            exp_busy   = 1'b0;
    logic            exp_done   = 1'b0;
    int              exp_id     = 0;
    int              exp_result = 0;

    // Converted value straight from the mode definitions.
    function automatic int conv(int data, int mode);
        case (mode)
            0:       return data / 100;
            1:       return data;
            2:       return data / 30;
            default: return (data * 12) / 30;
        endcase
    endfunction

    function automatic logic [18:0] pickData();
        case ($urandom_range(0, 7))
            0:       return 19'd0;
            1:       return 19'd29;
            2:       return 19'd30;
            3:       return 19'd99;
            4:       return 19'd100;
            5:       return 19'h7FFFF;
            default: return 19'($urandom);
        endcase
    endfunction

    task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
        vec_count++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, actual, expected);
        end
    endtask

    task automatic applyStimulus();
        for (int i = 0; i < NREQ; i++) begin
            bus.req[i]              = rq[i];
            bus.req_data[19*i +: 19] = dt[i];
            bus.req_mode[2*i +: 2]   = md[i];
        end
    endtask

    task automatic modelReset();
        pend_valid = 1'b0;
        free_cycle = cyc;
        last_div   = 1'b0;
        ptr_m      = 0;
        exp_grant  = '0;
        exp_busy   = 1'b0;
        exp_done   = 1'b0;
        exp_id     = 0;
        exp_result = 0;
    endtask

    // Advance one clock: update predicted registered outputs, drive the
    // current requests, then predict the grant and book the accepted job.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (pend_valid && pend_cycle == cyc) begin
            exp_done   = 1'b1;
            exp_id     = pend_id;
            exp_result = pend_val;
            pend_valid = 1'b0;
        end else begin
            exp_done = 1'b0;
        end
        exp_busy = last_div && (cyc < free_cycle);
        applyStimulus();
        exp_grant = '0;
        if (!rst && cyc >= free_cycle) begin
            for (int k = 0; k < NREQ; k++) begin
                int w;
                w = (ptr_m + k) % NREQ;
                if (rq[w]) begin
                    exp_grant[w] = 1'b1;
                    pend_valid   = 1'b1;
                    pend_id      = w;
                    pend_val     = conv(int'(dt[w]), int'(md[w]));
                    if (md[w] == 2'b01) begin
                        pend_cycle = cyc + 1;
                        last_div   = 1'b0;
                    end else begin
                        pend_cycle = cyc + 24;
                        last_div   = 1'b1;
                    end
                    free_cycle = pend_cycle;
                    ptr_m      = (w + 1) % NREQ;
                    break;
                end
            end
        end
        #1;
    endtask

    task automatic releaseGranted();
        for (int i = 0; i < NREQ; i++)
            if (exp_grant[i]) rq[i] = 1'b0;
    endtask

    task automatic drain(int n);
        for (int k = 0; k < n; k++) begin
            step();
            releaseGranted();
        end
    endtask

    // Single request from requester 0; checks the literal result and latency.
    task automatic runDirected(string name, logic [18:0] data, logic [1:0] mode,
                               int expected, int latency);
        int c0;
        bit seen;
        rq[0] = 1'b1;
        dt[0] = data;
        md[0] = mode;
        step();
        c0 = cyc;
        checkOutput({name, "_grant"}, 32'(bus.grant), 32'd1);
        rq[0] = 1'b0;
        seen  = 1'b0;
        for (int n = 0; n < 40 && !seen; n++) begin
            step();
            if (bus.done === 1'b1) begin
                seen = 1'b1;
                checkOutput({name, "_result"}, 32'(bus.result), 32'(expected));
                checkOutput({name, "_latency"}, 32'(cyc - c0), 32'(latency));
                checkOutput({name, "_id"}, 32'(bus.done_id), 32'd0);
            end
        end
        checkOutput({name, "_done_seen"}, 32'(seen), 32'd1);
    endtask

    // Every cycle, mid-period, every output must match the model.
    always @(negedge clk) begin
        if (checking) begin
            checkOutput("grant",   32'(bus.grant),   32'(exp_grant));
            checkOutput("busy",    32'(bus.busy),    32'(exp_busy));
            checkOutput("done",    32'(bus.done),    32'(exp_done));
            checkOutput("done_id", 32'(bus.done_id), 32'(exp_id));
            checkOutput("result",  32'(bus.result),  32'(exp_result));
        end
    end

    // Directed sequences followed by randomized traffic.
    initial begin
        bit seen;
        for (int i = 0; i < NREQ; i++) begin
            rq[i] = 1'b0;
            dt[i] = '0;
            md[i] = '0;
        end
        applyStimulus();

        // Pin the reference arithmetic itself.
        checkOutput("model_00_12345", 32'(conv(12345, 0)), 32'd123);
        checkOutput("model_11_max",   32'(conv(524287, 3)), 32'd209714);
        checkOutput("model_10_29",    32'(conv(29, 2)), 32'd0);

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        modelReset();
        #1;
        checkOutput("reset_busy",    32'(bus.busy),    32'd0);
        checkOutput("reset_done",    32'(bus.done),    32'd0);
        checkOutput("reset_result",  32'(bus.result),  32'd0);
        checkOutput("reset_done_id", 32'(bus.done_id), 32'd0);
        checkOutput("reset_grant",   32'(bus.grant),   32'd0);
        checking = 1'b1;

        // Both requesters held high: strict alternation starting with 0.
        rq[0] = 1'b1; dt[0] = 19'd4321;  md[0] = 2'b00;
        rq[1] = 1'b1; dt[1] = 19'd60000; md[1] = 2'b10;
        step();
        checkOutput("rot_first_grant", 32'(bus.grant), 32'd1);
        repeat (24) step();
        checkOutput("rot_second_grant", 32'(bus.grant), 32'd2);
        checkOutput("rot_first_id",     32'(bus.done_id), 32'd0);
        checkOutput("rot_first_result", 32'(bus.result), 32'd43);
        repeat (24) step();
        checkOutput("rot_third_grant",   32'(bus.grant), 32'd1);
        checkOutput("rot_second_id",     32'(bus.done_id), 32'd1);
        checkOutput("rot_second_result", 32'(bus.result), 32'd2000);
        releaseGranted();
        drain(60);

        runDirected("m00_12345", 19'd12345,  2'b00, 123,     24);
        runDirected("m11_max",   19'd524287, 2'b11, 209714,  24);
        runDirected("m10_29",    19'd29,     2'b10, 0,       24);
        runDirected("m10_30",    19'd30,     2'b10, 1,       24);
        runDirected("m00_0",     19'd0,      2'b00, 0,       24);
        runDirected("m01_max",   19'h7FFFF,  2'b01, 'h7FFFF, 1);

        // Requester 1 arrives mid-conversion; granted in id 0's done cycle.
        rq[0] = 1'b1; dt[0] = 19'd5000; md[0] = 2'b00;
        step();
        rq[0] = 1'b0;
        repeat (5) step();
        rq[1] = 1'b1; dt[1] = 19'd300; md[1] = 2'b10;
        seen = 1'b0;
        for (int n = 0; n < 40 && !seen; n++) begin
            step();
            if (bus.done === 1'b1) begin
                seen = 1'b1;
                checkOutput("late_grant_at_done", 32'(bus.grant), 32'd2);
                checkOutput("late_done_id",       32'(bus.done_id), 32'd0);
            end else begin
                checkOutput("late_grant_withheld", 32'(bus.grant), 32'd0);
            end
        end
        checkOutput("late_done_seen", 32'(seen), 32'd1);
        releaseGranted();
        drain(30);

        // Reset at cycle 10 of a mode-00 conversion aborts it.
        rq[0] = 1'b1; dt[0] = 19'd12345; md[0] = 2'b00;
        step();
        rq[0] = 1'b0;
        repeat (10) step();
        rst = 1'b1;
        modelReset();
        #1;
        checkOutput("abort_busy",    32'(bus.busy),    32'd0);
        checkOutput("abort_done",    32'(bus.done),    32'd0);
        checkOutput("abort_result",  32'(bus.result),  32'd0);
        checkOutput("abort_done_id", 32'(bus.done_id), 32'd0);
        repeat (2) step();
        rst = 1'b0;
        drain(40);
        rq[0] = 1'b1; dt[0] = 19'd777; md[0] = 2'b10;
        rq[1] = 1'b1; dt[1] = 19'd777; md[1] = 2'b11;
        step();
        checkOutput("post_reset_grant", 32'(bus.grant), 32'd1);
        releaseGranted();
        drain(60);

        // Randomized traffic; the compare process checks every cycle.
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (exp_grant[i]) begin
                    rq[i] = ($urandom_range(0, 3) == 0);
                    if (rq[i]) begin
                        dt[i] = pickData();
                        md[i] = 2'($urandom_range(0, 3));
                    end
                end else if (!rq[i] && $urandom_range(0, 7) == 0) begin
                    rq[i] = 1'b1;
                    dt[i] = pickData();
                    md[i] = 2'($urandom_range(0, 3));
                end
            end
            step();
        end
        releaseGranted();
        drain(60);

        checking = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

endmodule
